ltssm_timer_arbiter: RTL and testbench
======================================

# ltssm_timer_arbiter

Shares a single millisecond timeout timer between the RX and TX LTSSM masters. Each master requests the timer with a 6-bit duration in ms; the block arbitrates round-robin, runs a prescaled ms counter for the owner, and reports expiry only to that owner. It sits beside the LTSSM masters and replaces per-master setTimer/enableTimer/resetTimer/timeOut logic.

## Interface
- CLK_PER_MS, default 16: clock cycles per ms tick; legal range 2..65535. Small values are for simulation only.
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- reqRx  in  1  level request from RX master; held while timer is wanted
- setTimerRx  in  6  RX duration in ms; sampled only at grant
- restartRx  in  1  one-cycle pulse; restarts count with latched duration (owner only)
- reqTx, setTimerTx, restartTx  in  1/6/1  same for TX master
- grantRx  out  1  RX owns the timer
- grantTx  out  1  TX owns the timer
- timeOutRx  out  1  RX duration elapsed; held until RX releases or restarts
- timeOutTx  out  1  same for TX
- elapsedMs  out  6  whole ms elapsed for current owner; 0 when idle
- busy  out  1  timer owned (grantRx | grantTx)

## Operation
- FSM states: IDLE, RUN, EXPIRED. Internal: owner bit, lastOwner bit, latched duration[5:0], prescaler (clog2(CLK_PER_MS) bits), msCount[5:0].
- Reset: state IDLE, lastOwner = TX (RX wins first contention), all outputs 0.
- IDLE: one requester → grant it. Both → grant the one that is not lastOwner. On grant: latch that requester's setTimer, clear prescaler and msCount, set owner and lastOwner, go to RUN.
- RUN:
  - Owner's req low → IDLE, counters cleared. This overrides expiry and restart in the same cycle.
  - Owner's restart → clear prescaler and msCount, stay in RUN.
  - Otherwise prescaler increments. At CLK_PER_MS-1 it wraps to 0 and msCount increments.
  - When the incremented msCount equals duration → EXPIRED.
  - Duration 0 → EXPIRED on the first RUN edge.
- EXPIRED:
  - Owner timeOut held high.
  - Owner req low → IDLE.
  - Owner restart → RUN with counters cleared; timeOut drops next cycle.
  - Counters frozen; msCount = duration.
- Non-owner inputs (req, restart, setTimer) are ignored until the block returns to IDLE. The non-owner's req stays pending.
- setTimer changes after grant have no effect.
- No preemption: the owner keeps the timer until it drops req.

## Timing
- All outputs registered; they decode state/owner/msCount.
- Grant latency: req sampled high at edge n → grant high after edge n (cycle n+1). Cycle n+1 is prescaler count 0.
- Expiry: timeOut rises exactly duration×CLK_PER_MS cycles after grant rises (duration ≥ 1). Duration 0: timeOut rises 1 cycle after grant.
- elapsedMs increments on the edge where the prescaler wraps.
- Release: req low at edge m → grant and timeOut low after edge m. At least one IDLE cycle before any new grant, so handoff latency is 2 cycles from the owner dropping req to the other grant rising.
- Restart in RUN: cycle after the pulse has prescaler 0 and msCount 0. Full duration×CLK_PER_MS is re-timed from that cycle.
- grantRx and grantTx are never high together. timeOutX implies grantX.
- Async reset mid-RUN/EXPIRED: grant, timeOut, busy and elapsedMs drop without waiting for a clock edge. After reset deasserts, re-arbitration follows the IDLE rules.

## Test plan
- CLK_PER_MS=4, reqRx with setTimerRx=3 → grantRx in next cycle; elapsedMs steps 1,2,3 every 4 cycles; timeOutRx high exactly 12 cycles after grantRx; timeOutTx stays 0.
- reqRx and reqTx rise in the same cycle after reset → grantRx first. RX drops req → IDLE one cycle, then grantTx. Both re-request simultaneously later → TX-then-RX order alternates per round-robin.
- setTimerTx=2, restartTx pulsed 5 cycles after grant (CLK_PER_MS=4) → elapsedMs returns to 0; timeOutTx rises 8 cycles after the restart cycle. Restart in EXPIRED → timeOutTx low next cycle, re-expires 8 cycles later.
- setTimerRx=0 → timeOutRx 1 cycle after grantRx. restartTx pulses and setTimerTx changes while RX owns → no effect on RX timing.
- RX owner drops req on the same edge the expiry would occur → timeOutRx never asserts; grantRx low next cycle.
- Assert reset mid-RUN (msCount=2) → all outputs 0 immediately. Release reset with reqTx held → grantTx one cycle after first sampled edge; elapsedMs restarts from 0.

Source files
------------

// File: rtl/ltssm_timer_arbiter.sv
// ltssm_timer_arbiter: one millisecond timeout timer shared by the RX and TX
// LTSSM masters. The block arbitrates between them round-robin, runs a
// prescaled ms counter for the current owner, and flags expiry only to that owner.
//
// Handshake: reqX is a level request and grantX is a level acknowledgement.
// The master raises reqX and holds it for as long as it wants the timer.
// grantX rises one cycle after reqX is first sampled (when the timer is free).
// grantX stays high until the master drops reqX; it falls the cycle after that.
// There is no preemption. While one master owns the timer, every input from
// the other master is ignored, and its request stays pending.
`timescale 1ns/1ps
module ltssm_timer_arbiter #(
  parameter int CLK_PER_MS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqRx,
  input  logic [5:0] setTimerRx,
  input  logic       restartRx,
  input  logic       reqTx,
  input  logic [5:0] setTimerTx,
  input  logic       restartTx,
  output logic       grantRx,
  output logic       grantTx,
  output logic       timeOutRx,
  output logic       timeOutTx,
  output logic [5:0] elapsedMs,
  output logic       busy,
  output logic [1:0] dbgState
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);
  localparam logic OWN_RX = 1'b0;
  localparam logic OWN_TX = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } stateT;

  stateT         state, stateNext;
  logic          owner, ownerNext;
  logic          lastOwner, lastOwnerNext;
  logic [5:0]    duration, durationNext;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [5:0]    msCount, msCountNext;
  logic          ownerReq;
  logic          ownerRestart;
  logic [5:0]    msInc;

  assign ownerReq     = (owner == OWN_TX) ? reqTx : reqRx;
  assign ownerRestart = (owner == OWN_TX) ? restartTx : restartRx;
  assign msInc        = msCount + 6'd1;

  // Next-state, arbitration and counter logic; the default is to hold every register
  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastOwnerNext = lastOwner;
    durationNext  = duration;
    prescalerNext = prescaler;
    msCountNext   = msCount;
    case (state)
      IDLE: begin
        if (reqRx || reqTx) begin
          // When both masters request, the one that did not own the timer last time wins
          ownerNext     = (reqRx && reqTx) ? ~lastOwner : reqTx;
          lastOwnerNext = ownerNext;
          durationNext  = (ownerNext == OWN_TX) ? setTimerTx : setTimerRx;
          prescalerNext = '0;
          msCountNext   = '0;
          stateNext     = RUN;
        end
      end
      RUN: begin
        if (!ownerReq) begin
          // A release takes priority over a restart or an expiry on the same edge
          stateNext     = IDLE;
          prescalerNext = '0;
          msCountNext   = '0;
        end else if (ownerRestart) begin
          prescalerNext = '0;
          msCountNext   = '0;
        end else if (duration == 6'd0) begin
          stateNext = EXPIRED;
        end else if (prescaler == PRE_MAX) begin
          prescalerNext = '0;
          msCountNext   = msInc;
          if (msInc == duration) stateNext = EXPIRED;
        end else begin
          prescalerNext = prescaler + PW'(1);
        end
      end
      EXPIRED: begin
        // Counters stay frozen here, so msCount still equals duration
        if (!ownerReq) begin
          stateNext     = IDLE;
          prescalerNext = '0;
          msCountNext   = '0;
        end else if (ownerRestart) begin
          stateNext     = RUN;
          prescalerNext = '0;
          msCountNext   = '0;
        end
      end
      default: begin
        stateNext     = IDLE;
        prescalerNext = '0;
        msCountNext   = '0;
      end
    endcase
  end

  // State and datapath registers; lastOwner resets to TX so RX wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_RX;
      lastOwner <= OWN_TX;
      duration  <= '0;
      prescaler <= '0;
      msCount   <= '0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      lastOwner <= lastOwnerNext;
      duration  <= durationNext;
      prescaler <= prescalerNext;
      msCount   <= msCountNext;
    end
  end

  // Outputs decode registered state only, so an async reset clears them immediately
  always_comb begin
    busy      = (state != IDLE);
    grantRx   = busy && (owner == OWN_RX);
    grantTx   = busy && (owner == OWN_TX);
    timeOutRx = (state == EXPIRED) && (owner == OWN_RX);
    timeOutTx = (state == EXPIRED) && (owner == OWN_TX);
    elapsedMs = msCount;
    dbgState  = state;
  end

endmodule

// File: tb/tb_ltssm_timer_arbiter.sv
// Directed bench for ltssm_timer_arbiter with CLK_PER_MS=4. Inputs are driven
// and outputs are sampled on the falling edge. Expected values are worked out by hand.
`timescale 1ns/1ps
module tb_ltssm_timer_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqRx, restartRx, reqTx, restartTx;
  logic [5:0] setTimerRx, setTimerTx;
  logic       grantRx, grantTx, timeOutRx, timeOutTx, busy;
  logic [5:0] elapsedMs;
  logic [1:0] dbgState;

  int errCount   = 0;
  int checkCount = 0;

  ltssm_timer_arbiter #(.CLK_PER_MS(4)) dut (
    .clk(clk), .reset(reset),
    .reqRx(reqRx), .setTimerRx(setTimerRx), .restartRx(restartRx),
    .reqTx(reqTx), .setTimerTx(setTimerTx), .restartTx(restartTx),
    .grantRx(grantRx), .grantTx(grantTx),
    .timeOutRx(timeOutRx), .timeOutTx(timeOutTx),
    .elapsedMs(elapsedMs), .busy(busy), .dbgState(dbgState)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packs {grantRx, grantTx, timeOutRx, timeOutTx, busy, elapsedMs} into one vector
  task automatic expectOut(input string tag, input logic gRx, input logic gTx,
                           input logic toRx, input logic toTx, input logic [5:0] el);
    checkVal(tag, {5'b0, grantRx, grantTx, timeOutRx, timeOutTx, busy, elapsedMs},
                  {5'b0, gRx, gTx, toRx, toTx, gRx | gTx, el});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    reqRx = 1'b0; restartRx = 1'b0; setTimerRx = 6'd0;
    reqTx = 1'b0; restartTx = 1'b0; setTimerTx = 6'd0;
    step(1);
    expectOut("reset", 0, 0, 0, 0, 6'd0);
    checkVal("reset state", {14'b0, dbgState}, 16'd0);
    reset = 1'b0;
    step(1);
    expectOut("idle", 0, 0, 0, 0, 6'd0);

    // RX owns the timer with a 3 ms duration: expiry comes 12 cycles after the grant
    setTimerRx = 6'd3; reqRx = 1'b1;
    step(1);
    expectOut("t1 grant", 1, 0, 0, 0, 6'd0);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      expectOut($sformatf("t1 k%0d", k), 1, 0, (k >= 12), 0, (k >= 12) ? 6'd3 : 6'(k / 4));
    end
    checkVal("t1 state expired", {14'b0, dbgState}, 16'd2);
    reqRx = 1'b0;
    step(1);
    expectOut("t1 release", 0, 0, 0, 0, 6'd0);

    // Round-robin: the reset pulse lands between clock edges, then both masters request
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    setTimerRx = 6'd5; setTimerTx = 6'd5; reqRx = 1'b1; reqTx = 1'b1;
    step(1);
    expectOut("t2 rx first", 1, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t2 rx holds", 1, 0, 0, 0, 6'd0);
    reqRx = 1'b0;
    step(1);
    expectOut("t2 idle gap", 0, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t2 tx next", 0, 1, 0, 0, 6'd0);
    reqTx = 1'b0;
    step(1);
    expectOut("t2 idle a", 0, 0, 0, 0, 6'd0);
    reqRx = 1'b1;
    step(1);
    expectOut("t2 rx alone", 1, 0, 0, 0, 6'd0);
    reqRx = 1'b0;
    step(1);
    expectOut("t2 idle b", 0, 0, 0, 0, 6'd0);
    reqRx = 1'b1; reqTx = 1'b1;
    step(1);
    expectOut("t2 tx wins", 0, 1, 0, 0, 6'd0);
    reqTx = 1'b0;
    step(1);
    expectOut("t2 idle c", 0, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t2 rx after tx", 1, 0, 0, 0, 6'd0);
    reqRx = 1'b0;
    step(1);
    expectOut("t2 idle d", 0, 0, 0, 0, 6'd0);

    // TX owns the timer with 2 ms; a restart in RUN and then a restart in EXPIRED
    setTimerTx = 6'd2; reqTx = 1'b1;
    step(1);
    expectOut("t3 grant", 0, 1, 0, 0, 6'd0);
    step(4);
    expectOut("t3 ms1", 0, 1, 0, 0, 6'd1);
    step(1);
    expectOut("t3 pre restart", 0, 1, 0, 0, 6'd1);
    restartTx = 1'b1;
    step(1);
    expectOut("t3 restarted", 0, 1, 0, 0, 6'd0);
    restartTx = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      expectOut($sformatf("t3a k%0d", k), 0, 1, 0, (k >= 8), (k >= 8) ? 6'd2 : 6'(k / 4));
    end
    restartTx = 1'b1;
    step(1);
    expectOut("t3 exp restart", 0, 1, 0, 0, 6'd0);
    restartTx = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      expectOut($sformatf("t3b k%0d", k), 0, 1, 0, (k >= 8), (k >= 8) ? 6'd2 : 6'(k / 4));
    end
    reqTx = 1'b0;
    step(1);
    expectOut("t3 release", 0, 0, 0, 0, 6'd0);

    // Zero duration: timeOut comes one cycle after the grant
    setTimerRx = 6'd0; reqRx = 1'b1;
    step(1);
    expectOut("t4 zero grant", 1, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t4 zero expire", 1, 0, 1, 0, 6'd0);
    step(1);
    expectOut("t4 zero hold", 1, 0, 1, 0, 6'd0);
    reqRx = 1'b0;
    step(1);
    expectOut("t4 zero release", 0, 0, 0, 0, 6'd0);

    // While RX owns the timer, TX restarts and setTimer changes must have no effect
    setTimerRx = 6'd2; reqRx = 1'b1;
    step(1);
    expectOut("t4 rx grant", 1, 0, 0, 0, 6'd0);
    reqTx = 1'b1; restartTx = 1'b1; setTimerTx = 6'd20; setTimerRx = 6'd9;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      expectOut($sformatf("t4 k%0d", k), 1, 0, (k >= 8), 0, (k >= 8) ? 6'd2 : 6'(k / 4));
      restartTx  = ~restartTx;
      setTimerTx = 6'(k + 10);
      setTimerRx = 6'(k * 7);
    end
    restartTx = 1'b0; setTimerTx = 6'd1; reqRx = 1'b0;
    step(1);
    expectOut("t4 handoff gap", 0, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t4 tx grant", 0, 1, 0, 0, 6'd0);
    setTimerTx = 6'd30;
    step(3);
    expectOut("t4 tx k3", 0, 1, 0, 0, 6'd0);
    step(1);
    expectOut("t4 tx expire", 0, 1, 0, 1, 6'd1);
    reqTx = 1'b0;
    step(1);
    expectOut("t4 tx release", 0, 0, 0, 0, 6'd0);

    // RX releases on the edge where it would have expired
    setTimerRx = 6'd1; reqRx = 1'b1;
    step(1);
    expectOut("t5 grant", 1, 0, 0, 0, 6'd0);
    step(3);
    expectOut("t5 k3", 1, 0, 0, 0, 6'd0);
    reqRx = 1'b0;
    step(1);
    expectOut("t5 drop at expiry", 0, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t5 stays idle", 0, 0, 0, 0, 6'd0);

    // Async reset while msCount is 2, then re-arbitration with reqTx still held
    setTimerTx = 6'd5; reqTx = 1'b1;
    step(1);
    expectOut("t6 grant", 0, 1, 0, 0, 6'd0);
    step(8);
    expectOut("t6 ms2", 0, 1, 0, 0, 6'd2);
    step(1);
    expectOut("t6 ms2 hold", 0, 1, 0, 0, 6'd2);
    #2 reset = 1'b1;
    #1 expectOut("t6 async reset", 0, 0, 0, 0, 6'd0);
    step(1);
    expectOut("t6 reset held", 0, 0, 0, 0, 6'd0);
    reset = 1'b0;
    step(1);
    expectOut("t6 regrant", 0, 1, 0, 0, 6'd0);
    step(4);
    expectOut("t6 ms1", 0, 1, 0, 0, 6'd1);
    reqTx = 1'b0;
    step(1);
    expectOut("t6 release", 0, 0, 0, 0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
